// File: rtl/tdm_demux_1to4.sv
// One-to-four TDM demultiplexer: frame_sync-aligned samples fan out to four registered slot outputs.
// Define TDM_DEMUX_ERRCNT_EN to add the saturating 8-bit err_cnt output.
module tdm_demux_1to4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic [3:0]       dout_valid,
    output logic             frame_done,
    output logic             sync_err,
    output logic             locked
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              slot_q, slot_d;
    logic [3:0][WIDTH-1:0]   dout_q, dout_d;
    logic [3:0]              dv_q, dv_d;
    logic                    fd_q, fd_d;
    logic                    se_q, se_d;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        dout_d  = dout_q;
        dv_d    = '0;
        fd_d    = 1'b0;
        se_d    = 1'b0;
        if (din_valid) begin
            if (frame_sync) begin
                // A sync mid-frame abandons the partial frame but still starts a new one.
                se_d      = (state_q == StRun) && (slot_q != 2'd0);
                dout_d[0] = din;
                dv_d      = 4'b0001;
                slot_d    = 2'd1;
                state_d   = StRun;
            end else if (state_q == StRun) begin
                if (slot_q == 2'd0) begin
                    se_d    = 1'b1;
                    state_d = StIdle;
                end else begin
                    dout_d[slot_q] = din;
                    dv_d[slot_q]   = 1'b1;
                    fd_d           = (slot_q == 2'd3);
                    slot_d         = slot_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            slot_q  <= 2'd0;
            dout_q  <= '0;
            dv_q    <= '0;
            fd_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            fd_q    <= fd_d;
            se_q    <= se_d;
        end
    end

    assign dout0      = dout_q[0];
    assign dout1      = dout_q[1];
    assign dout2      = dout_q[2];
    assign dout3      = dout_q[3];
    assign dout_valid = dv_q;
    assign frame_done = fd_q;
    assign sync_err   = se_q;
    assign locked     = (state_q == StRun);

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (se_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Bench for tdm_demux_1to4: directed frame scenarios plus random traffic against a slot-tracking model.
module tb_tdm_demux_1to4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] dout0, dout1, dout2, dout3;
    logic [3:0] dout_valid;
    logic       frame_done, sync_err, locked;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    tdm_demux_1to4 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout0      (dout0),
        .dout1      (dout1),
        .dout2      (dout2),
        .dout3      (dout3),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
`ifdef TDM_DEMUX_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    bit check_en = 1'b0;

    // Model: which slot the next non-sync sample belongs to, or "not locked".
    logic [7:0] m_dout [4];
    logic [3:0] m_dv;
    bit         m_fd, m_se, m_lock;
    int         m_next;
    int         m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input bit fs, input logic [7:0] d);
        m_dv = 4'b0000;
        m_fd = 1'b0;
        m_se = 1'b0;
        if (r) begin
            for (int i = 0; i < 4; i++) m_dout[i] = 8'h00;
            m_lock = 1'b0;
            m_next = 0;
            m_err  = 0;
        end else if (v) begin
            if (fs) begin
                if (m_lock && m_next != 0) m_se = 1'b1;
                m_dout[0] = d;
                m_dv      = 4'b0001;
                m_next    = 1;
                m_lock    = 1'b1;
            end else if (m_lock) begin
                if (m_next == 0) begin
                    m_se   = 1'b1;
                    m_lock = 1'b0;
                end else begin
                    m_dout[m_next] = d;
                    m_dv           = 4'(1 << m_next);
                    m_fd           = (m_next == 3);
                    m_next         = (m_next + 1) % 4;
                end
            end
            if (m_se && m_err < 255) m_err++;
        end
    endtask

    task automatic step(input bit r, input bit v, input bit fs, input logic [7:0] d);
        rst = r;
        din_valid = v;
        frame_sync = fs;
        din = d;
        @(posedge clk);
        model(r, v, fs, d);
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), 8'($urandom));
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("dout0", 32'(dout0), 32'(m_dout[0]));
            chk("dout1", 32'(dout1), 32'(m_dout[1]));
            chk("dout2", 32'(dout2), 32'(m_dout[2]));
            chk("dout3", 32'(dout3), 32'(m_dout[3]));
            chk("dout_valid", 32'(dout_valid), 32'(m_dv));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("sync_err", 32'(sync_err), 32'(m_se));
            chk("locked", 32'(locked), 32'(m_lock));
`ifdef TDM_DEMUX_ERRCNT_EN
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_en = 1'b1;
        chk("rst_dout0", 32'(dout0), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_dv", 32'(dout_valid), 32'h0);

        // Back-to-back frame.
        step(1'b0, 1'b1, 1'b1, 8'h11);
        chk("f1_dv0", 32'(dout_valid), 32'h1);
        step(1'b0, 1'b1, 1'b0, 8'h22);
        chk("f1_dv1", 32'(dout_valid), 32'h2);
        step(1'b0, 1'b1, 1'b0, 8'h33);
        chk("f1_dv2", 32'(dout_valid), 32'h4);
        step(1'b0, 1'b1, 1'b0, 8'h44);
        chk("f1_dv3", 32'(dout_valid), 32'h8);
        chk("f1_done", 32'(frame_done), 32'h1);
        chk("f1_douts", {dout3, dout2, dout1, dout0}, 32'h44332211);
        chk("f1_locked", 32'(locked), 32'h1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("f1_done_drop", 32'(frame_done), 32'h0);

        // Same frame with 3-cycle gaps.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h11);
        gap(3);
        step(1'b0, 1'b1, 1'b0, 8'h22);
        gap(3);
        step(1'b0, 1'b1, 1'b0, 8'h33);
        gap(3);
        step(1'b0, 1'b1, 1'b0, 8'h44);
        chk("gap_done", 32'(frame_done), 32'h1);
        chk("gap_douts", {dout3, dout2, dout1, dout0}, 32'h44332211);
        chk("gap_noerr", 32'(sync_err), 32'h0);

        // Resync mid-frame.
        step(1'b0, 1'b1, 1'b1, 8'hA0);
        step(1'b0, 1'b1, 1'b0, 8'hA1);
        step(1'b0, 1'b1, 1'b1, 8'hB0);
        chk("rs_err", 32'(sync_err), 32'h1);
        chk("rs_d0", 32'(dout0), 32'hB0);
        chk("rs_d1", 32'(dout1), 32'hA1);
        chk("rs_nodone", 32'(frame_done), 32'h0);
        step(1'b0, 1'b1, 1'b0, 8'hB1);
        step(1'b0, 1'b1, 1'b0, 8'hB2);
        step(1'b0, 1'b1, 1'b0, 8'hB3);
        chk("rs_done", 32'(frame_done), 32'h1);

        // Missing sync after a complete frame drops lock.
        step(1'b0, 1'b1, 1'b0, 8'h55);
        chk("ul_err", 32'(sync_err), 32'h1);
        chk("ul_locked", 32'(locked), 32'h0);
        chk("ul_douts", {dout3, dout2, dout1, dout0}, 32'hB3B2B1B0);
        step(1'b0, 1'b1, 1'b0, 8'h66);
        step(1'b0, 1'b1, 1'b0, 8'h77);
        chk("ul_ignored", {dout3, dout2, dout1, dout0}, 32'hB3B2B1B0);
        chk("ul_idle_dv", 32'(dout_valid), 32'h0);
        step(1'b0, 1'b1, 1'b1, 8'h88);
        chk("ul_relock_d0", 32'(dout0), 32'h88);
        chk("ul_relock", 32'(locked), 32'h1);

        // Reset mid-frame.
        step(1'b0, 1'b1, 1'b0, 8'h99);
        step(1'b0, 1'b1, 1'b0, 8'h9A);
        step(1'b1, 1'b1, 1'b0, 8'h9B);
        chk("mr_douts", {dout3, dout2, dout1, dout0}, 32'h0);
        chk("mr_locked", 32'(locked), 32'h0);
        chk("mr_nodone", 32'(frame_done), 32'h0);
        step(1'b0, 1'b1, 1'b1, 8'hC0);
        chk("mr_restart", 32'(dout_valid), 32'h1);
        chk("mr_d0", 32'(dout0), 32'hC0);

`ifdef TDM_DEMUX_ERRCNT_EN
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 261; i++) step(1'b0, 1'b1, 1'b1, 8'(i));
        chk("ec_sat", 32'(err_cnt), 32'd255);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("ec_clr", 32'(err_cnt), 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 2), ($urandom_range(99) < 65),
                 ($urandom_range(99) < 25), 8'($urandom));
        end

        check_en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1to4.md
TDM_DEMUX_1TO4 -- requirements
Module: tdm_demux_1to4

Interface
REQ-001 Parameter: WIDTH, default 8, sample width in bits.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: din  input  WIDTH  TDM sample stream.
REQ-005 Port: din_valid  input  1  din carries a sample this cycle.
REQ-006 Port: frame_sync  input  1  qualified by din_valid; marks slot-0 sample.
REQ-007 Port: dout0..dout3  output  WIDTH each  registered per-slot sample.
REQ-008 Port: dout_valid  output  4  bit n pulses one cycle when doutn updated.
REQ-009 Port: frame_done  output  1  one-cycle pulse when slot 3 of an aligned frame is written.
REQ-010 Port: sync_err  output  1  one-cycle pulse on framing violation.
REQ-011 Port: locked  output  1  high while the FSM is in RUN.

Function
REQ-012 The FSM SHALL have two states, IDLE and RUN, plus a 2-bit slot counter.
REQ-013 frame_sync with din_valid=0 SHALL be ignored in every state.
REQ-014 IDLE: samples with frame_sync=0 SHALL be discarded with no output change.
REQ-015 IDLE: din_valid=1 with frame_sync=1 SHALL write din to dout0, set slot=1, and enter RUN.
REQ-016 RUN: din_valid=1 with frame_sync=0 and slot!=0 SHALL write din to dout[slot] and increment slot, wrapping 3->0.
REQ-017 RUN: din_valid=1 with frame_sync=1 and slot=0 SHALL write dout0 and set slot=1 (normal frame start).
REQ-018 RUN: din_valid=1 with frame_sync=1 and slot!=0 SHALL pulse sync_err, write din to dout0, set slot=1, and stay in RUN (resync; partial frame abandoned, no frame_done).
REQ-019 RUN: din_valid=1 with frame_sync=0 and slot=0 SHALL pulse sync_err, discard the sample, and return to IDLE.
REQ-020 Every write SHALL be visible on doutn and dout_valid[n] exactly 1 cycle after the accepting edge (latency 1); at most one dout_valid bit SHALL be set per cycle.
REQ-021 frame_done SHALL pulse in the same cycle as dout_valid[3], only when slots 0..3 were written consecutively without an intervening sync_err.
REQ-022 Unwritten doutn SHALL hold their previous value.
REQ-023 din_valid=0 SHALL leave the slot counter, state and all outputs unchanged, except that pulses SHALL deassert.
REQ-024 Gaps of any length between valid samples SHALL NOT affect framing.
REQ-025 locked SHALL be registered and equal to (state==RUN).

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set state=IDLE, slot=0, dout0..dout3=0, dout_valid=0, frame_done=0, sync_err=0, locked=0.
REQ-027 rst SHALL take priority over din_valid in the same cycle; a frame in progress SHALL be abandoned with no frame_done.
REQ-028 The first sample SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-029 Macro TDM_DEMUX_ERRCNT_EN defined: the block SHALL add output port err_cnt (8 bits), which increments on each sync_err pulse, saturates at 255, and is cleared to 0 by rst.
REQ-030 Macro TDM_DEMUX_ERRCNT_EN undefined: err_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then frame 0x11(fs=1), 0x22, 0x33, 0x44 on consecutive cycles -> dout0..3=11,22,33,44; dout_valid=0001,0010,0100,1000 one cycle after each; frame_done with the last pulse; locked=1.
REQ-032 Same frame with din_valid=0 gaps of 3 cycles between samples -> identical dout values and frame_done; no sync_err.
REQ-033 In RUN after 0xA0(fs=1), 0xA1, send 0xB0 with fs=1 -> sync_err pulse, dout0=B0, dout1 stays A1, no frame_done; the next three samples complete the frame and frame_done pulses.
REQ-034 After a full frame, send 0x55 with fs=0 -> sync_err pulse, dout unchanged, locked=0; samples 0x66, 0x77 with fs=0 are ignored; 0x88 with fs=1 -> dout0=88, locked=1.
REQ-035 Assert rst for one cycle after slot 2 is written -> all outputs 0, locked=0, no frame_done; a subsequent fs=1 sample restarts at slot 0.
REQ-036 With TDM_DEMUX_ERRCNT_EN defined, drive 260 forced sync errors -> err_cnt reads 255; rst -> err_cnt reads 0.
